multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the multi-cycle MIPS datapath (shared memory, IR, ALUOut, MDR registers)
//  for add, sub, slt, jr, j, bne, lw, sw and xori. It replaces single-cycle decode with per-state
//  strobes. Sits beside the datapath: takes op/funct from IR, zero from ALU, mem_rdy from memory.
// PARAMETERS
//  USE_MEM_RDY  1  1: memory states wait for mem_rdy; 0: memory is single-cycle, mem_rdy ignored (treated 1)
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high
//  op        in   6  IR[31:26]; valid from DECODE onward
//  funct     in   6  IR[5:0]; valid from DECODE onward
//  zero      in   1  ALU zero flag, same cycle
//  mem_rdy   in   1  memory access completes this cycle
//  PCWr      out  1  load PC
//  IRWr      out  1  load IR from memory read data
//  IorD      out  1  memory address: 0=PC, 1=ALUOut
//  MemRd     out  1  memory read strobe
//  MemWr     out  1  memory write strobe
//  RegWr     out  1  register file write
//  RegDst    out  1  write reg: 0=rt, 1=rd
//  MemToReg  out  1  write data: 0=ALUOut, 1=MDR
//  ALUSrcA   out  1  0=PC, 1=rs
//  ALUSrcB   out  2  00=rt, 01=const 4, 10=extended imm, 11=sign-ext imm<<2
//  ZeroExt   out  1  imm extension: 1=zero-extend (xori), 0=sign-extend
//  ALUcntrl  out  2  00 add, 10 sub, 01 xor, 11 slt
//  PCSrc     out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target, 11=rs (jr)
//  instr_done out 1  one-cycle pulse in last state of each instruction
//  err       out  1  sticky: unsupported op/funct decoded
//  state     out  4  current state (debug)
// BEHAVIOUR
//  - Reset: state<=FETCH, err<=0; while reset high all outputs 0 (strobes gated by reset).
//  - Unlisted outputs are 0 in every state; no X outputs anywhere.
//  - FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUcntrl=00, PCSrc=00. IRWr=PCWr=mem_rdy.
//    Stay while !mem_rdy; ->DECODE when mem_rdy.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUcntrl=00 (branch target to ALUOut). Next:
//    op=000010 (j): PCWr=1, PCSrc=10, instr_done=1 ->FETCH.
//    op=0, funct=001000 (jr): PCWr=1, PCSrc=11, instr_done=1 ->FETCH.
//    op=0, funct add 100000/sub 100010/slt 101010 ->EXEC_R; op=001110 ->EXEC_I;
//    op=000101 ->BRANCH; op=100011 or 101011 ->MEMADR; anything else ->ERROR.
//  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUcntrl add=00/sub=10/slt=11 ->WB_R.
//  - WB_R: RegWr=1, RegDst=1, MemToReg=0, instr_done=1 ->FETCH.
//  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ZeroExt=1, ALUcntrl=01 ->WB_I.
//  - WB_I: RegWr=1, RegDst=0, MemToReg=0, instr_done=1 ->FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUcntrl=10, PCSrc=01, PCWr=~zero, instr_done=1 ->FETCH.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ZeroExt=0, ALUcntrl=00; ->MEMRD if lw, ->MEMWR if sw.
//  - MEMRD: MemRd=1, IorD=1; hold until mem_rdy ->WB_MEM.
//  - WB_MEM: RegWr=1, RegDst=0, MemToReg=1, instr_done=1 ->FETCH.
//  - MEMWR: MemWr=1, IorD=1; hold (MemWr stays high) until mem_rdy; then instr_done=1 ->FETCH.
//  - ERROR: err=1, all strobes 0, terminal until reset.
//  - mem_rdy outside FETCH/MEMRD/MEMWR is ignored. USE_MEM_RDY=0: every memory state lasts 1 cycle.
//  - CPI: j/jr 2, bne 3, R/xori 4, sw 4, lw 5 (+ wait cycles per memory access).
//  - Reset asserted mid-instruction: immediate abort, no further strobes; restart at FETCH after release.
// TESTING
//  add (op=0,funct=100000), mem_rdy=1 -> FETCH,DECODE,EXEC_R(ALUcntrl=00),WB_R(RegWr=1,RegDst=1); 4 cycles
//  lw (op=100011), mem_rdy low 2 cycles in MEMRD -> MEMRD held 3 cycles, WB_MEM MemToReg=1; 7 cycles total
//  bne with zero=1 -> PCWr=0 in BRANCH; zero=0 -> PCWr=1, PCSrc=01; instr_done pulses once
//  j then jr -> each 2 cycles, PCSrc=10 then 11, PCWr=1 in DECODE, no RegWr/MemWr ever
//  op=011110 -> ERROR, err=1 held, all strobes 0 for 20 cycles; reset -> err=0, FETCH
//  sw, reset asserted during MEMWR -> MemWr drops asynchronously, restart FETCH with MemRd=1 after release

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle MIPS datapath that shares one memory for
// instructions and data and holds intermediate values in IR, ALUOut and MDR.
// Supported instructions: add, sub, slt, jr, j, bne, lw, sw, xori.
// Every instruction starts in FETCH. Control strobes come from the current
// state, qualified where noted by mem_rdy (memory handshake) or zero (ALU flag).
//
// Parameters
//   USE_MEM_RDY  1: FETCH/MEMRD/MEMWR wait for mem_rdy
//                0: memory is single-cycle and mem_rdy is treated as 1
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high; forces every output to 0
//   op         in   6  IR[31:26], valid from DECODE onward
//   funct      in   6  IR[5:0], valid from DECODE onward
//   zero       in   1  ALU zero flag (same cycle)
//   mem_rdy    in   1  memory access completes this cycle
//   PCWr       out  1  load PC
//   IRWr       out  1  load IR from memory read data
//   IorD       out  1  memory address select: 0=PC, 1=ALUOut
//   MemRd      out  1  memory read strobe
//   MemWr      out  1  memory write strobe
//   RegWr      out  1  register file write enable
//   RegDst     out  1  destination register: 0=rt, 1=rd
//   MemToReg   out  1  write-back data: 0=ALUOut, 1=MDR
//   ALUSrcA    out  1  ALU A operand: 0=PC, 1=rs
//   ALUSrcB    out  2  ALU B operand: 00=rt, 01=4, 10=ext imm, 11=sext imm<<2
//   ZeroExt    out  1  immediate extension: 1=zero, 0=sign
//   ALUcntrl   out  2  00 add, 10 sub, 01 xor, 11 slt
//   PCSrc      out  2  00=ALU, 01=ALUOut, 10=jump target, 11=rs
//   instr_done out  1  pulse in the last cycle of each instruction
//   err        out  1  sticky flag: unsupported op/funct decoded
//   state      out  4  current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter bit USE_MEM_RDY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       PCWr,
    output logic       IRWr,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ZeroExt,
    output logic [1:0] ALUcntrl,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_BRANCH = 4'd6,
        S_MEMADR = 4'd7,
        S_MEMRD  = 4'd8,
        S_WB_MEM = 4'd9,
        S_MEMWR  = 4'd10,
        S_ERROR  = 4'd11
    } state_t;

    // Opcodes and R-type function codes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    // ALU operand B selections
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    // PC source selections
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // R-type arithmetic functions that go through EXEC_R/WB_R
    function automatic logic is_r_alu(input logic [5:0] fn);
        logic hit;
        case (fn)
            FN_ADD, FN_SUB, FN_SLT: hit = 1'b1;
            default:                hit = 1'b0;
        endcase
        return hit;
    endfunction

    // ALU operation for an R-type arithmetic function
    function automatic logic [1:0] r_alu_op(input logic [5:0] fn);
        logic [1:0] alu_op;
        case (fn)
            FN_SUB:  alu_op = ALU_SUB;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
        return alu_op;
    endfunction

    state_t     state_r;
    state_t     next_state_s;
    logic       err_r;
    logic       rdy_s;

    logic       pc_wr_s;
    logic       ir_wr_s;
    logic       i_or_d_s;
    logic       mem_rd_s;
    logic       mem_wr_s;
    logic       reg_wr_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       zero_ext_s;
    logic [1:0] alu_cntrl_s;
    logic [1:0] pc_src_s;
    logic       instr_done_s;

    // Effective memory handshake: a single-cycle memory is always ready
    always_comb begin
        if (USE_MEM_RDY) begin
            rdy_s = mem_rdy;
        end else begin
            rdy_s = 1'b1;
        end
    end

    // State register and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == S_ERROR) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        next_state_s = state_r;
        pc_wr_s      = 1'b0;
        ir_wr_s      = 1'b0;
        i_or_d_s     = 1'b0;
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        reg_wr_s     = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_RT;
        zero_ext_s   = 1'b0;
        alu_cntrl_s  = ALU_ADD;
        pc_src_s     = PC_ALU;
        instr_done_s = 1'b0;

        case (state_r)
            S_FETCH: begin
                // PC+4 is computed every cycle, but PC and IR only load
                // on the cycle the read completes.
                mem_rd_s    = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                ir_wr_s     = rdy_s;
                pc_wr_s     = rdy_s;
                if (rdy_s) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end

            S_DECODE: begin
                // Branch target goes to ALUOut speculatively.
                alu_src_b_s = SRCB_BRIMM;
                case (op)
                    OP_J: begin
                        pc_wr_s      = 1'b1;
                        pc_src_s     = PC_JUMP;
                        instr_done_s = 1'b1;
                        next_state_s = S_FETCH;
                    end
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_wr_s      = 1'b1;
                            pc_src_s     = PC_RS;
                            instr_done_s = 1'b1;
                            next_state_s = S_FETCH;
                        end else if (is_r_alu(funct)) begin
                            next_state_s = S_EXEC_R;
                        end else begin
                            next_state_s = S_ERROR;
                        end
                    end
                    OP_XORI:      next_state_s = S_EXEC_I;
                    OP_BNE:       next_state_s = S_BRANCH;
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    default:      next_state_s = S_ERROR;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = SRCB_RT;
                alu_cntrl_s  = r_alu_op(funct);
                next_state_s = S_WB_R;
            end

            S_WB_R: begin
                reg_wr_s     = 1'b1;
                reg_dst_s    = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end

            S_EXEC_I: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = SRCB_IMM;
                zero_ext_s   = 1'b1;
                alu_cntrl_s  = ALU_XOR;
                next_state_s = S_WB_I;
            end

            S_WB_I: begin
                reg_wr_s     = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end

            S_BRANCH: begin
                // Compare rs-rt; take the ALUOut target when not equal.
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = SRCB_RT;
                alu_cntrl_s  = ALU_SUB;
                pc_src_s     = PC_ALUOUT;
                pc_wr_s      = ~zero;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end

            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_cntrl_s = ALU_ADD;
                case (op)
                    OP_LW:   next_state_s = S_MEMRD;
                    OP_SW:   next_state_s = S_MEMWR;
                    default: next_state_s = S_ERROR;
                endcase
            end

            S_MEMRD: begin
                mem_rd_s = 1'b1;
                i_or_d_s = 1'b1;
                if (rdy_s) begin
                    next_state_s = S_WB_MEM;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end

            S_WB_MEM: begin
                reg_wr_s     = 1'b1;
                mem_to_reg_s = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end

            S_MEMWR: begin
                // Write strobe held until the memory accepts it.
                mem_wr_s     = 1'b1;
                i_or_d_s     = 1'b1;
                instr_done_s = rdy_s;
                if (rdy_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end

            S_ERROR: begin
                next_state_s = S_ERROR;
            end

            default: begin
                // Unused encodings are treated as a fault.
                next_state_s = S_ERROR;
            end
        endcase
    end

    // Output stage: reset forces every output low immediately
    always_comb begin
        if (reset) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            IorD       = 1'b0;
            MemRd      = 1'b0;
            MemWr      = 1'b0;
            RegWr      = 1'b0;
            RegDst     = 1'b0;
            MemToReg   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ZeroExt    = 1'b0;
            ALUcntrl   = 2'b00;
            PCSrc      = 2'b00;
            instr_done = 1'b0;
            err        = 1'b0;
            state      = 4'd0;
        end else begin
            PCWr       = pc_wr_s;
            IRWr       = ir_wr_s;
            IorD       = i_or_d_s;
            MemRd      = mem_rd_s;
            MemWr      = mem_wr_s;
            RegWr      = reg_wr_s;
            RegDst     = reg_dst_s;
            MemToReg   = mem_to_reg_s;
            ALUSrcA    = alu_src_a_s;
            ALUSrcB    = alu_src_b_s;
            ZeroExt    = zero_ext_s;
            ALUcntrl   = alu_cntrl_s;
            PCSrc      = pc_src_s;
            instr_done = instr_done_s;
            err        = err_r;
            state      = state_r;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. For every instruction the bench
// builds the expected per-cycle control vector from the instruction's
// cycle-by-cycle description (fetch with wait cycles, decode, execute/memory
// steps, write-back) and compares the DUT outputs against it cycle by cycle.
// Directed sequences cover reset, the error trap and reset during a store.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       iord;
        logic       memrd;
        logic       memwr;
        logic       regwr;
        logic       regdst;
        logic       memtoreg;
        logic       srca;
        logic [1:0] srcb;
        logic       zext;
        logic [1:0] aluc;
        logic [1:0] pcsrc;
        logic       done;
        logic       err;
    } outs_t;

    typedef struct {
        outs_t      o;
        logic       rdy;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        int         id;
        int         cyc;
    } cyc_t;

    localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_JR = 3, K_J = 4;
    localparam int K_BNE = 5, K_LW = 6, K_SW = 7, K_XORI = 8, K_BAD = 9;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_rdy;
    logic       PCWr, IRWr, IorD, MemRd, MemWr, RegWr, RegDst, MemToReg, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ZeroExt;
    logic [1:0] ALUcntrl;
    logic [1:0] PCSrc;
    logic       instr_done;
    logic       err;
    logic [3:0] state;
    outs_t      dut_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   instr_id = 0;
    cyc_t q[$];

    multicycle_ctrl #(.USE_MEM_RDY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_rdy(mem_rdy), .PCWr(PCWr), .IRWr(IRWr), .IorD(IorD),
        .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr), .RegDst(RegDst),
        .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ZeroExt(ZeroExt), .ALUcntrl(ALUcntrl), .PCSrc(PCSrc),
        .instr_done(instr_done), .err(err), .state(state)
    );

    assign dut_o = {PCWr, IRWr, IorD, MemRd, MemWr, RegWr, RegDst, MemToReg,
                    ALUSrcA, ALUSrcB, ZeroExt, ALUcntrl, PCSrc, instr_done, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            K_ADD:   return "add";
            K_SUB:   return "sub";
            K_SLT:   return "slt";
            K_JR:    return "jr";
            K_J:     return "j";
            K_BNE:   return "bne";
            K_LW:    return "lw";
            K_SW:    return "sw";
            K_XORI:  return "xori";
            default: return "bad";
        endcase
    endfunction

    task automatic push(input outs_t o, input logic rdy, input logic z,
                        input logic [5:0] opv, input logic [5:0] fnv,
                        input int kind, input int cyc);
        cyc_t c;
        c.o = o; c.rdy = rdy; c.z = z; c.op = opv; c.fn = fnv;
        c.kind = kind; c.id = instr_id; c.cyc = cyc;
        q.push_back(c);
    endtask

    // Expected cycle sequence of one instruction. fw/mw: wait cycles before
    // mem_rdy in the fetch and data-memory access; z: ALU zero during bne.
    task automatic gen_instr(input int kind, input logic z, input int fw, input int mw,
                             input int err_cycles);
        outs_t      o;
        logic [5:0] opv;
        logic [5:0] fnv;
        int         cyc = 0;
        fnv = 6'($urandom_range(0, 63));
        case (kind)
            K_ADD:   begin opv = 6'b000000; fnv = 6'b100000; end
            K_SUB:   begin opv = 6'b000000; fnv = 6'b100010; end
            K_SLT:   begin opv = 6'b000000; fnv = 6'b101010; end
            K_JR:    begin opv = 6'b000000; fnv = 6'b001000; end
            K_J:     opv = 6'b000010;
            K_BNE:   opv = 6'b000101;
            K_LW:    opv = 6'b100011;
            K_SW:    opv = 6'b101011;
            K_XORI:  opv = 6'b001110;
            default: opv = 6'b011110;
        endcase
        instr_id++;
        // fetch: read at PC, PC+4 through the ALU, load PC/IR when ready
        for (int i = 0; i <= fw; i++) begin
            o = '0; o.memrd = 1'b1; o.srcb = 2'b01;
            o.irwr = (i == fw); o.pcwr = (i == fw);
            push(o, (i == fw), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63)), kind, cyc++);
        end
        // decode: branch target precomputed; jumps finish here
        o = '0; o.srcb = 2'b11;
        if (kind == K_J) begin o.pcwr = 1'b1; o.pcsrc = 2'b10; o.done = 1'b1; end
        if (kind == K_JR) begin o.pcwr = 1'b1; o.pcsrc = 2'b11; o.done = 1'b1; end
        push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
        case (kind)
            K_ADD, K_SUB, K_SLT: begin
                o = '0; o.srca = 1'b1; o.srcb = 2'b00;
                o.aluc = (kind == K_ADD) ? 2'b00 : ((kind == K_SUB) ? 2'b10 : 2'b11);
                push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
                o = '0; o.regwr = 1'b1; o.regdst = 1'b1; o.done = 1'b1;
                push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
            end
            K_XORI: begin
                o = '0; o.srca = 1'b1; o.srcb = 2'b10; o.zext = 1'b1; o.aluc = 2'b01;
                push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
                o = '0; o.regwr = 1'b1; o.done = 1'b1;
                push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
            end
            K_BNE: begin
                o = '0; o.srca = 1'b1; o.aluc = 2'b10; o.pcsrc = 2'b01;
                o.pcwr = ~z; o.done = 1'b1;
                push(o, 1'($urandom_range(0, 1)), z, opv, fnv, kind, cyc++);
            end
            K_LW, K_SW: begin
                o = '0; o.srca = 1'b1; o.srcb = 2'b10;
                push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
                for (int i = 0; i <= mw; i++) begin
                    o = '0; o.iord = 1'b1;
                    if (kind == K_LW) o.memrd = 1'b1;
                    else begin o.memwr = 1'b1; o.done = (i == mw); end
                    push(o, (i == mw), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
                end
                if (kind == K_LW) begin
                    o = '0; o.regwr = 1'b1; o.memtoreg = 1'b1; o.done = 1'b1;
                    push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opv, fnv, kind, cyc++);
                end
            end
            K_J, K_JR: begin
            end
            default: begin
                // trapped: only err stays high, whatever the inputs do
                for (int i = 0; i < err_cycles; i++) begin
                    o = '0; o.err = 1'b1;
                    push(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), kind, cyc++);
                end
            end
        endcase
    endtask

    // Drive up to n queued cycles (n<0: all). Entered and left at posedge+1.
    task automatic run_queue(input int n);
        cyc_t c;
        int   done_n = 0;
        while (q.size() > 0 && (n < 0 || done_n < n)) begin
            c = q.pop_front();
            op = c.op; funct = c.fn; mem_rdy = c.rdy; zero = c.z;
            @(negedge clk);
            check_eq($sformatf("%s#%0d.c%0d", kname(c.kind), c.id, c.cyc),
                     32'(dut_o), 32'(c.o));
            @(posedge clk);
            #1;
            done_n++;
        end
    endtask

    initial begin
        int kinds_dir[10] = '{K_ADD, K_LW, K_BNE, K_BNE, K_J, K_JR, K_SW, K_SUB, K_SLT, K_XORI};
        logic zs_dir[10]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int mws_dir[10]   = '{0, 2, 0, 0, 0, 0, 1, 0, 0, 0};

        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_rdy = 1'b1;
        // reset state: every output low, state reads FETCH (0)
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", 32'(dut_o), 32'd0);
        check_eq("reset_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // directed: one of each instruction, lw with two memory wait cycles
        for (int i = 0; i < 10; i++) begin
            gen_instr(kinds_dir[i], zs_dir[i], 0, mws_dir[i], 0);
        end
        run_queue(-1);

        // randomized instruction stream with random wait cycles
        for (int i = 0; i < 70; i++) begin
            gen_instr(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
        end
        run_queue(-1);

        // unsupported opcode: trap for 20 cycles, then reset clears err
        gen_instr(K_BAD, 1'b0, 1, 0, 20);
        run_queue(-1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("err_reset_outputs", 32'(dut_o), 32'd0);
        check_eq("err_reset_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        gen_instr(K_ADD, 1'b0, 0, 0, 0);
        run_queue(-1);

        // sw: reset asserted in the middle of a held MEMWR cycle
        gen_instr(K_SW, 1'b0, 0, 3, 0);
        run_queue(4);
        mem_rdy = 1'b0;
        @(negedge clk);
        check_eq("sw_memwr_held", 32'(MemWr), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("sw_reset_memwr", 32'(MemWr), 32'd0);
        check_eq("sw_reset_outputs", 32'(dut_o), 32'd0);
        @(posedge clk);
        #1;
        check_eq("sw_reset_state", 32'(state), 32'd0);
        reset = 1'b0;
        q.delete();
        gen_instr(K_ADD, 1'b0, 1, 0, 0);
        gen_instr(K_LW, 1'b0, 0, 1, 0);
        run_queue(-1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion before 200000");
        $fatal(1);
    end

endmodule
